uart_tx_frame: RTL and testbench

Parametrised UART transmitter that replaces the split "busy + external bit-counter + data mux" transmit scheme with one self-timed block. It accepts a byte over a valid/ready handshake and generates its own bit timing from `clk_ref`. It supports configurable data width, runtime parity mode and one or two stop bits, and drives the serial pin directly. It sits between the application or FIFO read side and the RS-232 pad.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_tx_frame.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, the frame FSM state type and
// parity helper functions used by the transmit (and later receive) frames.
package uart_pkg;

  // Parity mode codes as seen on the runtime mode input (3 also means none)
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Frame FSM state type, kept as a plain vector for legacy compatibility
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // True when the mode inserts a parity bit after the data bits
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit for up to 9 data bits; unused upper bits must be zero
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    logic bit_s;
    case (mode)
      PAR_NONE: bit_s = 1'b1;
      PAR_EVEN: bit_s = ^data;
      PAR_ODD:  bit_s = ~^data;
      default:  bit_s = 1'b1;
    endcase
    return bit_s;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Transmit-side handshake and status bundle between a byte source and
// uart_tx_frame. The source uses the master modport, the transmitter the slave.
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  logic              i_tx_valid;
  logic [DATA_W-1:0] i_tx_dat;
  logic [1:0]        i_parity_mode;
  logic              i_stop2;
  logic              o_tx_ready;
  logic              o_tx_busy;
  logic              o_tx_done;
  logic              o_tx_pin;

  modport master (
    output i_tx_valid, i_tx_dat, i_parity_mode, i_stop2,
    input  o_tx_ready, o_tx_busy, o_tx_done, o_tx_pin
  );

  modport slave (
    input  i_tx_valid, i_tx_dat, i_parity_mode, i_stop2,
    output o_tx_ready, o_tx_busy, o_tx_done, o_tx_pin
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..CLK_DIV-1 and flags the last cycle of each
// bit. The flag is registered; bit_end_next is its value for the next cycle,
// letting the frame FSM register outputs that must line up with bit_end.
module uart_baud_tick #(
  parameter int CLK_DIV = 434
) (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx_s;
  logic          bit_end_r;

  // Next count: restart on clear, otherwise wrap at the end of a bit
  always_comb begin
    cnt_nx_s = cnt_r;
    if (clear) begin
      cnt_nx_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nx_s = '0;
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end
  end

  assign bit_end_next = (cnt_nx_s == CNT_MAX);
  assign bit_end      = bit_end_r;

  // Counter and registered end-of-bit flag
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      bit_end_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx_s;
      bit_end_r <= bit_end_next;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Self-timed UART transmitter: takes one frame over a valid/ready handshake,
// latches payload and framing options, and shifts start, data (LSB first),
// optional parity and one or two stop bits onto a registered serial pin.
// All status outputs are registered from next-state values so that done,
// ready and not-busy coincide with the last cycle of the final stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int DATA_W  = 8
) (
  input  logic           clk_ref,
  input  logic           rst_n,
  uart_tx_frame_if.slave tx_if
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

  uart_state_t       state_r, state_nx_s;
  logic [DATA_W-1:0] shift_r, shift_nx_s;
  logic [DATA_W-1:0] data_r, data_nx_s;
  logic [1:0]        mode_r, mode_nx_s;
  logic              stop2_r, stop2_nx_s;
  logic [BW-1:0]     bcnt_r, bcnt_nx_s;
  logic              pin_r, pin_nx_s;
  logic              ready_r, busy_r, done_r;
  logic              ready_nx_s, done_nx_s, last_stop_nx_s;
  logic              accept_s, bit_end_s, bit_end_nx_s;

  assign accept_s = tx_if.i_tx_valid & ready_r;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_ref      (clk_ref),
    .rst_n        (rst_n),
    .clear        (accept_s),
    .bit_end      (bit_end_s),
    .bit_end_next (bit_end_nx_s)
  );

  // Frame sequencing: state, payload latch, shift register and bit counter
  always_comb begin
    state_nx_s = state_r;
    shift_nx_s = shift_r;
    data_nx_s  = data_r;
    mode_nx_s  = mode_r;
    stop2_nx_s = stop2_r;
    bcnt_nx_s  = bcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          data_nx_s  = tx_if.i_tx_dat;
          shift_nx_s = tx_if.i_tx_dat;
          mode_nx_s  = tx_if.i_parity_mode;
          stop2_nx_s = tx_if.i_stop2;
          bcnt_nx_s  = '0;
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          bcnt_nx_s  = '0;
          state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bcnt_r == BCNT_LAST) begin
            bcnt_nx_s  = '0;
            state_nx_s = has_parity(mode_r) ? ST_PARITY : ST_STOP;
          end else begin
            bcnt_nx_s  = bcnt_r + BCNT_ONE;
            shift_nx_s = shift_r >> 1;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          bcnt_nx_s  = '0;
          state_nx_s = ST_STOP;
        end else begin
          state_nx_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (!stop2_r || (bcnt_r == BCNT_ONE)) begin
            bcnt_nx_s = '0;
            if (accept_s) begin
              data_nx_s  = tx_if.i_tx_dat;
              shift_nx_s = tx_if.i_tx_dat;
              mode_nx_s  = tx_if.i_parity_mode;
              stop2_nx_s = tx_if.i_stop2;
              state_nx_s = ST_START;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else begin
            bcnt_nx_s = BCNT_ONE;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      default: begin
        bcnt_nx_s  = '0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Pin value and status lookahead for the cycle after this edge
  always_comb begin
    pin_nx_s = 1'b1;
    case (state_nx_s)
      ST_IDLE:   pin_nx_s = 1'b1;
      ST_START:  pin_nx_s = 1'b0;
      ST_DATA:   pin_nx_s = shift_nx_s[0];
      ST_PARITY: pin_nx_s = parity_bit(9'(data_nx_s), mode_nx_s);
      ST_STOP:   pin_nx_s = 1'b1;
      default:   pin_nx_s = 1'b1;
    endcase
    last_stop_nx_s = !stop2_nx_s || (bcnt_nx_s == BCNT_ONE);
    done_nx_s      = (state_nx_s == ST_STOP) && last_stop_nx_s && bit_end_nx_s;
    ready_nx_s     = (state_nx_s == ST_IDLE) || done_nx_s;
  end

  // Sequential state and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      data_r  <= '0;
      mode_r  <= 2'd0;
      stop2_r <= 1'b0;
      bcnt_r  <= '0;
      pin_r   <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      shift_r <= shift_nx_s;
      data_r  <= data_nx_s;
      mode_r  <= mode_nx_s;
      stop2_r <= stop2_nx_s;
      bcnt_r  <= bcnt_nx_s;
      pin_r   <= pin_nx_s;
      ready_r <= ready_nx_s;
      busy_r  <= !ready_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign tx_if.o_tx_pin   = pin_r;
  assign tx_if.o_tx_ready = ready_r;
  assign tx_if.o_tx_busy  = busy_r;
  assign tx_if.o_tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed plus randomized bench for uart_tx_frame. Expected pin waveforms are
// built from the frame format (start, LSB-first data, parity, stop bits) and
// compared cycle by cycle together with ready/busy/done.
module tb_uart_tx_frame;

  localparam int CLK_DIV = 4;
  localparam int DATA_W  = 8;

  logic clk_ref = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];

  always #5 clk_ref = ~clk_ref;

  uart_tx_frame_if #(.DATA_W(DATA_W)) tx_if ();

  uart_tx_frame #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_dut (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .tx_if   (tx_if)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Reference frame: one entry per bit time
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] mode, input logic s2);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) exp_q.push_back(d[i]);
    if (mode == 2'd1) exp_q.push_back(($countones(d) % 2) == 1);
    else if (mode == 2'd2) exp_q.push_back(($countones(d) % 2) == 0);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endfunction

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_ref);
      chk($sformatf("%s_pin", tag), tx_if.o_tx_pin, 1'b1);
      chk($sformatf("%s_ready", tag), tx_if.o_tx_ready, 1'b1);
      chk($sformatf("%s_busy", tag), tx_if.o_tx_busy, 1'b0);
      chk($sformatf("%s_done", tag), tx_if.o_tx_done, 1'b0);
    end
  endtask

  // Present a frame while idle; returns right after the accepting edge
  task automatic start_frame(input logic [7:0] d, input logic [1:0] mode, input logic s2);
    @(negedge clk_ref);
    chk("pre_ready", tx_if.o_tx_ready, 1'b1);
    chk("pre_busy", tx_if.o_tx_busy, 1'b0);
    tx_if.i_tx_valid    = 1'b1;
    tx_if.i_tx_dat      = d;
    tx_if.i_parity_mode = mode;
    tx_if.i_stop2       = s2;
    @(posedge clk_ref);
  endtask

  // Check one whole frame starting the cycle after its accept edge.
  // hold keeps valid high and presents the next frame's fields; otherwise
  // valid drops, inputs are scrambled and a stray valid pulse hits mid-frame.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] mode, input logic s2,
                           input bit hold, input logic [7:0] nd, input logic [1:0] nmode,
                           input logic ns2);
    int len;
    build_frame(d, mode, s2);
    len = exp_q.size() * CLK_DIV;
    for (int k = 0; k < len; k++) begin
      @(negedge clk_ref);
      chk($sformatf("pin d=%02h m=%0d s2=%0b k=%0d", d, mode, s2, k), tx_if.o_tx_pin, exp_q[k / CLK_DIV]);
      chk($sformatf("ready d=%02h k=%0d", d, k), tx_if.o_tx_ready, k == len - 1);
      chk($sformatf("busy d=%02h k=%0d", d, k), tx_if.o_tx_busy, k != len - 1);
      chk($sformatf("done d=%02h k=%0d", d, k), tx_if.o_tx_done, k == len - 1);
      if (k == 0) begin
        if (hold) begin
          tx_if.i_tx_dat      = nd;
          tx_if.i_parity_mode = nmode;
          tx_if.i_stop2       = ns2;
        end else begin
          tx_if.i_tx_valid    = 1'b0;
          tx_if.i_tx_dat      = 8'($urandom);
          tx_if.i_parity_mode = 2'($urandom);
          tx_if.i_stop2       = 1'($urandom);
        end
      end else if (!hold && k == len / 2) begin
        tx_if.i_tx_valid = 1'b1;
        tx_if.i_tx_dat   = 8'($urandom);
      end else if (!hold && k == len / 2 + 1) begin
        tx_if.i_tx_valid = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] mode, input logic s2);
    start_frame(d, mode, s2);
    run_frame(d, mode, s2, 1'b0, 8'h00, 2'd0, 1'b0);
    idle_check(3, "after");
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rm;
    logic       rs;
    tx_if.i_tx_valid    = 1'b0;
    tx_if.i_tx_dat      = 8'h00;
    tx_if.i_parity_mode = 2'd0;
    tx_if.i_stop2       = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_ref);
    chk("rst_pin", tx_if.o_tx_pin, 1'b1);
    chk("rst_ready", tx_if.o_tx_ready, 1'b1);
    chk("rst_busy", tx_if.o_tx_busy, 1'b0);
    chk("rst_done", tx_if.o_tx_done, 1'b0);
    rst_n = 1'b1;
    idle_check(2, "idle");

    // Basic frame, then parity variants, then two stop bits
    send(8'hA5, 2'd0, 1'b0);
    send(8'hA5, 2'd1, 1'b0);
    send(8'h07, 2'd1, 1'b0);
    send(8'h07, 2'd2, 1'b0);
    send(8'h55, 2'd0, 1'b1);
    send(8'hFF, 2'd3, 1'b1);

    // Back-to-back with valid held high
    start_frame(8'h01, 2'd0, 1'b0);
    run_frame(8'h01, 2'd0, 1'b0, 1'b1, 8'h80, 2'd2, 1'b1);
    run_frame(8'h80, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
    idle_check(3, "b2b_after");

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      rm = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      send(rd, rm, rs);
    end

    // Reset in the middle of the data bits
    start_frame(8'hC3, 2'd1, 1'b1);
    @(negedge clk_ref);
    tx_if.i_tx_valid = 1'b0;
    repeat (13) @(negedge clk_ref);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pin", tx_if.o_tx_pin, 1'b1);
    chk("mid_rst_ready", tx_if.o_tx_ready, 1'b1);
    chk("mid_rst_busy", tx_if.o_tx_busy, 1'b0);
    chk("mid_rst_done", tx_if.o_tx_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_ref);
      chk("in_rst_done", tx_if.o_tx_done, 1'b0);
      chk("in_rst_pin", tx_if.o_tx_pin, 1'b1);
    end
    rst_n = 1'b1;
    idle_check(60, "post_rst");
    send(8'h3C, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
